// File: rtl/controle_porta.sv
// Door sequencing controller: motor, LEDs and 7-segment status from button, limit switches,
// obstacle and lock, with auto-close timer, motion watchdog and safety reopen.
module controle_porta #(
  parameter int T_ABERTO = 8,
  parameter int T_MOTOR  = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             botao,
  input  logic             trava,
  input  logic             sensor_aberto,
  input  logic             sensor_fechado,
  input  logic             obstaculo,
  output logic             motor_abrir,
  output logic             motor_fechar,
  output logic             ledVerde,
  output logic             ledVermelho,
  output logic [6:0]       HEX,
  output logic [2:0]       estado
);

  typedef enum logic [2:0] {
    FECHADO  = 3'd0,
    ABRINDO  = 3'd1,
    ABERTO   = 3'd2,
    FECHANDO = 3'd3,
    ERRO     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LIM_ABERTO = CNT_W'(T_ABERTO - 1);
  localparam logic [CNT_W-1:0] LIM_MOTOR  = CNT_W'(T_MOTOR - 1);
  localparam logic [CNT_W-1:0] T_MAX      = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] t_reg, t_next;
  logic             hold;

  // {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX}
  function automatic logic [10:0] decode(input state_t s);
    case (s)
      FECHADO:  decode = {4'b0001, 7'b0001110};
      ABRINDO:  decode = {4'b1001, 7'b0001000};
      ABERTO:   decode = {4'b0010, 7'b1000000};
      FECHANDO: decode = {4'b0101, 7'b1000110};
      default:  decode = {4'b0011, 7'b0000110};
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    hold       = 1'b0;
    case (state_reg)
      FECHADO: if (botao && !trava) state_next = ABRINDO;
      ABRINDO: begin
        if (sensor_aberto && sensor_fechado) state_next = ERRO;
        else if (sensor_aberto)              state_next = ABERTO;
        else if (t_reg == LIM_MOTOR)         state_next = ERRO;
      end
      ABERTO: begin
        if (botao || obstaculo)       hold       = 1'b1;
        else if (t_reg == LIM_ABERTO) state_next = FECHANDO;
      end
      FECHANDO: begin
        if (sensor_aberto && sensor_fechado) state_next = ERRO;
        else if (obstaculo || botao)         state_next = ABRINDO;
        else if (sensor_fechado)             state_next = FECHADO;
        else if (t_reg == LIM_MOTOR)         state_next = ERRO;
      end
      ERRO:    state_next = ERRO;
      default: state_next = ERRO;
    endcase
  end

  always_comb begin
    if (state_next != state_reg || state_next == FECHADO || state_next == ERRO || hold)
      t_next = '0;
    else if (t_reg == T_MAX)
      t_next = t_reg;
    else
      t_next = t_reg + 1'b1;
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FECHADO;
      t_reg     <= '0;
      estado    <= 3'd0;
      {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX} <= decode(FECHADO);
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      estado    <= state_next;
      {motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX} <= decode(state_next);
    end
  end

endmodule

// File: tb/tb_controle_porta.sv
// Scoreboard bench for controle_porta: directed scenarios plus random stimulus against a
// cycle-count reference model of the door sequencing rules.
module tb_controle_porta;

  localparam int T_ABERTO = 8;
  localparam int T_MOTOR  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic botao = 1'b0, trava = 1'b0, sensor_aberto = 1'b0, sensor_fechado = 1'b0, obstaculo = 1'b0;
  logic motor_abrir, motor_fechar, ledVerde, ledVermelho;
  logic [6:0] HEX;
  logic [2:0] estado;

  controle_porta #(.T_ABERTO(T_ABERTO), .T_MOTOR(T_MOTOR), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .botao(botao), .trava(trava),
    .sensor_aberto(sensor_aberto), .sensor_fechado(sensor_fechado), .obstaculo(obstaculo),
    .motor_abrir(motor_abrir), .motor_fechar(motor_fechar), .ledVerde(ledVerde),
    .ledVermelho(ledVermelho), .HEX(HEX), .estado(estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned edge_n;
    logic [13:0] outs;   // {estado, motor_abrir, motor_fechar, verde, vermelho, HEX}
  } exp_t;

  exp_t q[$];
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: door phase plus number of cycles already spent in it.
  localparam int S_F = 0, S_A = 1, S_O = 2, S_C = 3, S_E = 4;
  int m_st  = S_F;
  int m_age = 0;

  function automatic logic [13:0] expected_outs(input int s);
    case (s)
      S_F:     return {3'd0, 4'b0001, 7'b0001110};
      S_A:     return {3'd1, 4'b1001, 7'b0001000};
      S_O:     return {3'd2, 4'b0010, 7'b1000000};
      S_C:     return {3'd3, 4'b0101, 7'b1000110};
      default: return {3'd4, 4'b0011, 7'b0000110};
    endcase
  endfunction

  task automatic model(input logic b, tr, sa, sf, ob, rs);
    int nxt;
    nxt = m_st;
    if (rs) nxt = S_F;
    else begin
      case (m_st)
        S_F: if (b && !tr) nxt = S_A;
        S_A: begin
          if (sa && sf) nxt = S_E;
          else if (sa) nxt = S_O;
          else if (m_age + 1 >= T_MOTOR) nxt = S_E;   // motor has run its full allowance
        end
        S_O: begin
          if (b || ob) m_age = -1;                    // door held: count restarts afterwards
          else if (m_age + 1 >= T_ABERTO) nxt = S_C;
        end
        S_C: begin
          if (sa && sf) nxt = S_E;
          else if (ob || b) nxt = S_A;
          else if (sf) nxt = S_F;
          else if (m_age + 1 >= T_MOTOR) nxt = S_E;
        end
        default: nxt = S_E;
      endcase
    end
    if (nxt != m_st || rs) m_age = 0;
    else m_age = m_age + 1;
    m_st = nxt;
  endtask

  task automatic step(input logic b, tr, sa, sf, ob, rs);
    exp_t e;
    @(posedge clock);
    #1;
    botao = b; trava = tr; sensor_aberto = sa; sensor_fechado = sf; obstaculo = ob; reset = rs;
    model(b, tr, sa, sf, ob, rs);
    e.edge_n = cyc + 1;
    e.outs   = expected_outs(m_st);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs once the edge an expectation refers to has occurred.
  initial begin
    exp_t e;
    logic [13:0] act;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].edge_n <= cyc) begin
        e = q.pop_front();
        act = {estado, motor_abrir, motor_fechar, ledVerde, ledVermelho, HEX};
        checks++;
        if (act !== e.outs) begin
          errors++;
          $display("FAIL outputs edge %0d: got estado=%0d ma=%b mf=%b verde=%b verm=%b HEX=%b, expected estado=%0d ma=%b mf=%b verde=%b verm=%b HEX=%b",
                   e.edge_n, act[13:11], act[10], act[9], act[8], act[7], act[6:0],
                   e.outs[13:11], e.outs[10], e.outs[9], e.outs[8], e.outs[7], e.outs[6:0]);
        end
        if (act[10] && act[9]) begin
          errors++;
          $display("FAIL motor_exclusive edge %0d: both motor outputs high", e.edge_n);
        end
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    $display("phase: reset and idle");
    idle(5);

    $display("phase: normal open/close cycle");
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    idle(9);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    idle(2);

    $display("phase: obstacle reopen while closing, obstacle hold while open");
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0);
    idle(9);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    idle(10);
    step(0, 0, 0, 1, 0, 0);

    $display("phase: lock in FECHADO");
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("phase: opening watchdog and ERRO");
    idle(T_MOTOR + 2);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
    idle(2);

    $display("phase: sensor fault in FECHANDO, late limit switch in ABRINDO");
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(T_ABERTO + 1);
    step(0, 0, 1, 1, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    idle(T_MOTOR - 1);
    step(0, 0, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(T_ABERTO);
    step(0, 0, 0, 1, 1, 0);
    idle(3);

    $display("phase: random stimulus");
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 12, $urandom_range(99) < 30, $urandom_range(99) < 12,
           $urandom_range(99) < 12, $urandom_range(99) < 6, $urandom_range(99) < 2);
    end
    idle(3);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_porta.md
# controle_porta

Sequencing controller for the door system: drives the door motor (open/close), the green/red LEDs and the 7-segment status digit from a button, two limit switches, an obstacle sensor and a lock input. It is the timed state machine that owns the door mechanism, with an auto-close timer, a motion watchdog and safety reopen. The 7-segment digit is active-low, segment order {g,f,e,d,c,b,a}.

## Interface
- `T_ABERTO`, default 8: cycles the door stays open before auto-close (≥2).
- `T_MOTOR`, default 16: maximum motion cycles before watchdog fault (≥2).
- `CNT_W`, default 8: timer width; must hold max(T_ABERTO, T_MOTOR).
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `botao` in 1: open request (level, synchronous to `clock`).
- `trava` in 1: lock; inhibits opening from FECHADO only.
- `sensor_aberto` in 1: fully-open limit switch.
- `sensor_fechado` in 1: fully-closed limit switch.
- `obstaculo` in 1: obstacle in doorway.
- `motor_abrir` out 1: drive motor in the open direction.
- `motor_fechar` out 1: drive motor in the close direction.
- `ledVerde` out 1: green LED.
- `ledVermelho` out 1: red LED.
- `HEX` out 7: status digit, active-low.
- `estado` out 3: current state code.

## Operation
- States and codes: FECHADO=0, ABRINDO=1, ABERTO=2, FECHANDO=3, ERRO=4. Codes 5–7 are illegal and go to ERRO on the next edge.
- Timer `t`:
  - Cleared to 0 on every state change and in FECHADO/ERRO.
  - Otherwise increments each cycle and saturates at all-ones.
- Transitions, highest priority first within each state:
  - FECHADO: `botao & ~trava` → ABRINDO.
  - ABRINDO:
    - `sensor_aberto & sensor_fechado` → ERRO (sensor fault).
    - `sensor_aberto` → ABERTO.
    - `t == T_MOTOR-1` → ERRO.
  - ABERTO:
    - `botao | obstaculo` → stay and clear `t`.
    - `t == T_ABERTO-1` → FECHANDO.
  - FECHANDO:
    - Both sensors high → ERRO.
    - `obstaculo | botao` → ABRINDO (reopen; `trava` ignored).
    - `sensor_fechado` → FECHADO.
    - `t == T_MOTOR-1` → ERRO.
  - ERRO: held until `reset`.
- Outputs are a Moore decode of the state register. `motor_abrir` and `motor_fechar` are never both 1.
  - FECHADO: motors 0/0, verde=0, vermelho=1, HEX=0001110 ('F').
  - ABRINDO: motor_abrir=1, verde=0, vermelho=1, HEX=0001000 ('A').
  - ABERTO: motors 0/0, verde=1, vermelho=0, HEX=1000000 ('O').
  - FECHANDO: motor_fechar=1, verde=0, vermelho=1, HEX=1000110 ('C').
  - ERRO: motors 0/0, verde=1, vermelho=1, HEX=0000110 ('E').
  - `estado` = state code.

## Timing
- Reset:
  - The `reset` edge forces FECHADO and `t`=0.
  - From the next cycle: motors 0/0, ledVerde=0, ledVermelho=1, HEX=0001110, estado=0.
  - Reset mid-motion stops the motor within one cycle.
- Latency: an input sampled at edge k changes the outputs in the cycle after edge k. There is no input registering.
- Motion watchdog: with no limit switch asserted, the motor is on for exactly T_MOTOR cycles, then ERRO.
- Auto-close: with no `botao`/`obstaculo`, ABERTO lasts exactly T_ABERTO cycles.
- Each `botao`/`obstaculo` cycle in ABERTO restarts the full T_ABERTO count after its deassertion.
- Simultaneous events:
  - Limit switch and watchdog timeout at the same edge: the limit switch wins.
  - `obstaculo` and `sensor_fechado` at the same edge in FECHANDO: reopen wins.
  - Both sensors high in a motion state: ERRO wins over everything.
- `trava` has no effect outside FECHADO.

## Test plan
Benches use T_ABERTO=8, T_MOTOR=16.
- Reset then idle 5 cycles → estado=0, HEX=0001110, vermelho=1, motors 0.
- `botao` for 1 cycle, `sensor_aberto` 4 cycles later → ABRINDO ('A', motor_abrir=1) for 4 cycles, then ABERTO ('O', verde=1) for 8 cycles, then FECHANDO ('C'). `sensor_fechado` 3 cycles later → FECHADO.
- In FECHANDO, pulse `obstaculo` → next cycle ABRINDO with `t`=0. In ABERTO, hold `obstaculo` 5 cycles → FECHANDO exactly 8 cycles after release.
- `trava`=1 with `botao`=1 in FECHADO for 10 cycles → stays FECHADO. Drop `trava` → ABRINDO next cycle.
- ABRINDO with no sensor → motor_abrir high exactly 16 cycles, then ERRO (HEX=0000110, both LEDs 1). `botao` in ERRO is ignored. `reset` → FECHADO.
- Both sensors high during FECHANDO → ERRO next cycle. `sensor_aberto` at `t`=15 in ABRINDO → ABERTO, not ERRO.
